// File: rtl/lac_pkg.sv
// rtl/lac_pkg.sv - shared codes for the logic-analyzer trigger sequencer
package lac_pkg;

  localparam logic [1:0] FLD_MASK  = 2'd0;
  localparam logic [1:0] FLD_COND  = 2'd1;
  localparam logic [1:0] FLD_COUNT = 2'd2;
  localparam logic [1:0] FLD_CTRL  = 2'd3;

  localparam int CTRL_LAST = 0;
  localparam int CTRL_NEG  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRIG  = 2'd2
  } state_t;

endpackage

// File: rtl/lac_trig_cmp.sv
// rtl/lac_trig_cmp.sv - mask/compare/negate match for one trigger stage
module lac_trig_cmp #(
  parameter int width = 8
) (
  input  logic [width-1:0] probe,
  input  logic [width-1:0] mask,
  input  logic [width-1:0] cond,
  input  logic             neg,
  output logic             match
);

  assign match = ((probe & mask) == (cond & mask)) ^ neg;

endmodule

// File: rtl/lac_trig_seq.sv
// rtl/lac_trig_seq.sv - multi-stage trigger sequencer with byte-wide config table
module lac_trig_seq #(
  parameter int width     = 8,
  parameter int stages    = 4,
  parameter int cnt_width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_adr,
  input  logic [7:0]       cfg_dat,
  input  logic             arm,
  input  logic             disarm,
  input  logic [width-1:0] probe,
  output logic             armed,
  output logic             triggered,
  output logic             trig,
  output logic [1:0]       stage,
  output logic             cfg_err
);
  import lac_pkg::*;

  // Table lives in flops so that every field is cleared by reset.
  logic [width-1:0]     mask_t  [stages];
  logic [width-1:0]     cond_t  [stages];
  logic [cnt_width-1:0] count_t [stages];
  logic [7:0]           ctrl_t  [stages];

  state_t               state;
  logic [cnt_width-1:0] cnt;

  logic                 match;
  logic                 in_range;
  logic                 wr_ok;
  logic [cnt_width-1:0] cnt_inc;
  logic [cnt_width-1:0] eff_count;
  logic                 done;
  logic                 is_final;

  lac_trig_cmp #(.width(width)) u_cmp (
    .probe (probe),
    .mask  (mask_t[stage]),
    .cond  (cond_t[stage]),
    .neg   (ctrl_t[stage][CTRL_NEG]),
    .match (match)
  );

  assign in_range  = int'(cfg_adr[3:2]) < stages;
  assign wr_ok     = cfg_we && in_range && (state != S_ARMED);
  assign cnt_inc   = (&cnt) ? cnt : cnt + cnt_width'(1);
  assign eff_count = (count_t[stage] == '0) ? cnt_width'(1) : count_t[stage];
  assign done      = match && (cnt_inc >= eff_count);
  assign is_final  = ctrl_t[stage][CTRL_LAST] || (stage == 2'(stages - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < stages; i++) begin
        mask_t[i]  <= '0;
        cond_t[i]  <= '0;
        count_t[i] <= '0;
        ctrl_t[i]  <= '0;
      end
    end else if (wr_ok) begin
      case (cfg_adr[1:0])
        FLD_MASK:  mask_t[cfg_adr[3:2]]  <= width'(cfg_dat);
        FLD_COND:  cond_t[cfg_adr[3:2]]  <= width'(cfg_dat);
        FLD_COUNT: count_t[cfg_adr[3:2]] <= cnt_width'(cfg_dat);
        default:   ctrl_t[cfg_adr[3:2]]  <= cfg_dat;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      stage     <= '0;
      armed     <= 1'b0;
      triggered <= 1'b0;
      trig      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      trig <= 1'b0;
      if (cfg_we && in_range && state == S_ARMED) cfg_err <= 1'b1;
      // disarm outranks arm, and both outrank this cycle's probe sample
      if (disarm) begin
        state     <= S_IDLE;
        cnt       <= '0;
        stage     <= '0;
        armed     <= 1'b0;
        triggered <= 1'b0;
      end else if (arm) begin
        state     <= S_ARMED;
        cnt       <= '0;
        stage     <= '0;
        armed     <= 1'b1;
        triggered <= 1'b0;
        cfg_err   <= 1'b0;
      end else if (state == S_ARMED) begin
        if (!match) begin
          cnt <= '0;
        end else if (!done) begin
          cnt <= cnt_inc;
        end else if (is_final) begin
          state     <= S_TRIG;
          cnt       <= '0;
          armed     <= 1'b0;
          triggered <= 1'b1;
          trig      <= 1'b1;
        end else begin
          stage <= stage + 2'd1;
          cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lac_trig_seq.sv
// tb/tb_lac_trig_seq.sv - directed self-checking bench for lac_trig_seq
module tb_lac_trig_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_we;
  logic [3:0] cfg_adr;
  logic [7:0] cfg_dat;
  logic       arm;
  logic       disarm;
  logic [7:0] probe;
  logic       armed;
  logic       triggered;
  logic       trig;
  logic [1:0] stage;
  logic       cfg_err;

  int tests  = 0;
  int failed = 0;
  int seen;

  lac_trig_seq #(.width(8), .stages(4), .cnt_width(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_adr   (cfg_adr),
    .cfg_dat   (cfg_dat),
    .arm       (arm),
    .disarm    (disarm),
    .probe     (probe),
    .armed     (armed),
    .triggered (triggered),
    .trig      (trig),
    .stage     (stage),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] adr, input logic [7:0] dat);
    cfg_we = 1'b1; cfg_adr = adr; cfg_dat = dat;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
  endtask

  task automatic drive(input logic [7:0] p);
    probe = p;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_adr = '0; cfg_dat = '0;
    arm = 1'b0; disarm = 1'b0; probe = '0;
    #1;
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_triggered", 32'(triggered), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_stage", 32'(stage), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // single-stage trigger
    cfg_write(4'h0, 8'hFF); cfg_write(4'h1, 8'hA5);
    cfg_write(4'h2, 8'h01); cfg_write(4'h3, 8'h01);
    pulse_arm();
    chk("t1_armed", 32'(armed), 32'd1);
    drive(8'h00); chk("t1_trig_s0", 32'(trig), 32'd0);
    drive(8'h00); chk("t1_trig_s1", 32'(trig), 32'd0);
    drive(8'hA5); chk("t1_trig_hit", 32'(trig), 32'd1);
    chk("t1_triggered", 32'(triggered), 32'd1);
    chk("t1_armed_off", 32'(armed), 32'd0);
    chk("t1_stage", 32'(stage), 32'd0);
    drive(8'hA5); chk("t1_trig_once", 32'(trig), 32'd0);
    chk("t1_triggered_hold", 32'(triggered), 32'd1);

    // consecutive repeat count, configured from TRIGGERED
    cfg_write(4'h0, 8'h0F); cfg_write(4'h1, 8'h03);
    cfg_write(4'h2, 8'h03); cfg_write(4'h3, 8'h01);
    pulse_arm();
    chk("t2_triggered_clr", 32'(triggered), 32'd0);
    chk("t2_armed", 32'(armed), 32'd1);
    drive(8'h13); drive(8'h23); chk("t2_pair", 32'(trig), 32'd0);
    drive(8'h00); drive(8'h03); drive(8'hF3);
    chk("t2_fifth", 32'(trig), 32'd0);
    drive(8'h33); chk("t2_sixth", 32'(trig), 32'd1);

    // three-stage sequence with negated final stage; stage 0 count 0 acts as 1
    pulse_disarm();
    chk("t3_idle_triggered", 32'(triggered), 32'd0);
    cfg_write(4'h0, 8'hFF); cfg_write(4'h1, 8'h11);
    cfg_write(4'h2, 8'h00); cfg_write(4'h3, 8'h00);
    cfg_write(4'h4, 8'hFF); cfg_write(4'h5, 8'h22);
    cfg_write(4'h6, 8'h01); cfg_write(4'h7, 8'h00);
    cfg_write(4'h8, 8'h80); cfg_write(4'h9, 8'h80);
    cfg_write(4'hA, 8'h01); cfg_write(4'hB, 8'h03);
    pulse_arm();
    drive(8'h11); chk("t3_stage1", 32'(stage), 32'd1);
    drive(8'h22); chk("t3_stage2", 32'(stage), 32'd2);
    drive(8'h80); chk("t3_hold", 32'(stage), 32'd2);
    chk("t3_no_trig", 32'(trig), 32'd0);
    drive(8'h7F); chk("t3_trig", 32'(trig), 32'd1);
    chk("t3_stage_final", 32'(stage), 32'd2);

    // config write while armed is dropped and flagged
    pulse_arm();
    cfg_write(4'h1, 8'h55);
    chk("t4_cfg_err", 32'(cfg_err), 32'd1);
    drive(8'h11); chk("t4_table_kept", 32'(stage), 32'd1);
    chk("t4_err_sticky", 32'(cfg_err), 32'd1);
    pulse_arm();
    chk("t4_err_clr", 32'(cfg_err), 32'd0);
    chk("t4_restart", 32'(stage), 32'd0);

    // simultaneous arm+disarm, then re-arm from stage 2
    arm = 1'b1; disarm = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0;
    chk("t5_both_armed", 32'(armed), 32'd0);
    pulse_arm();
    drive(8'h11); drive(8'h22);
    chk("t5_at_stage2", 32'(stage), 32'd2);
    probe = 8'h7F;
    pulse_arm();
    chk("t5_rearm_stage", 32'(stage), 32'd0);
    chk("t5_rearm_no_trig", 32'(trig), 32'd0);
    chk("t5_rearm_armed", 32'(armed), 32'd1);

    // async reset during the trig cycle
    drive(8'h11); drive(8'h22); drive(8'h7F);
    chk("t6_pre_trig", 32'(trig), 32'd1);
    chk("t6_pre_stage", 32'(stage), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_trig_cut", 32'(trig), 32'd0);
    chk("t6_triggered", 32'(triggered), 32'd0);
    chk("t6_stage", 32'(stage), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulse_arm();
    drive(8'h00);
    chk("t6_table_zero", 32'(stage), 32'd1);
    chk("t6_no_last", 32'(trig), 32'd0);
    pulse_disarm();

    // count 255 advances on exactly the 255th consecutive match
    cfg_write(4'h0, 8'h00); cfg_write(4'h1, 8'h00);
    cfg_write(4'h2, 8'hFF); cfg_write(4'h3, 8'h01);
    pulse_arm();
    seen = 0;
    for (int i = 0; i < 254; i++) begin
      drive(8'h5A);
      if (trig) seen++;
    end
    chk("t7_early", 32'(seen), 32'd0);
    drive(8'h5A); chk("t7_255th", 32'(trig), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lac_trig_seq.md
# lac_trig_seq

Multi-stage trigger sequencer for the logic analyzer's probe clock domain. It holds a small table of per-stage match conditions (mask, compare value, repeat count, control flags) and steps through them against the registered probe word. When the final stage completes, it raises a one-cycle `trig` pulse, which drives the sampling machinery's trigger/write-enable in place of its single mask/compare match. The table is written through a byte-wide config port, which the UART command decoder drives after its clock-domain crossing.

## Interface
- `width`, 8: probe word width. The config port is byte-wide, so only 8 is supported.
- `stages`, 4: number of trigger stages. Must be a power of two, at most 4.
- `cnt_width`, 8: repeat-counter width.

- `clk`  in  1: probe clock. All logic is on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cfg_we`  in  1: config write strobe, one byte per cycle.
- `cfg_adr`  in  4: {stage[1:0], field[1:0]}. Field 0 = mask, 1 = cond, 2 = count, 3 = ctrl.
- `cfg_dat`  in  8: config write data.
- `arm`  in  1: single-cycle pulse; start the sequence at stage 0.
- `disarm`  in  1: single-cycle pulse; abort or clear and return to idle.
- `probe`  in  width: registered probe sample, valid every cycle.
- `armed`  out  1: sequencer is in the ARMED state.
- `triggered`  out  1: level; set on trigger, held until `disarm`.
- `trig`  out  1: one-cycle pulse on trigger.
- `stage`  out  2: current stage index.
- `cfg_err`  out  1: sticky; set by a dropped config write, cleared by `arm`.

## Operation
- **Config table:** per stage, mask[7:0], cond[7:0], count[cnt_width-1:0] and ctrl[7:0].
  - ctrl bit0 = `last` (this stage ends the sequence).
  - ctrl bit1 = `neg` (invert the match).
  - Other ctrl bits are stored but have no effect.
- **Config writes:**
  - Accepted only in IDLE or TRIGGERED.
  - A write while ARMED is dropped and sets `cfg_err`.
  - Writes to stage indices ≥ `stages` are dropped silently.
- **Match:** match = (((probe & mask) == (cond & mask)) XOR neg), evaluated on stage[`stage`]. A mask of 0 with neg=0 always matches.
- **Effective count:** count = 0 is treated as 1.
- **States:**
  - **IDLE:** all status outputs low. `arm` loads stage=0 and cnt=0, then goes to ARMED.
  - **ARMED:**
    - Match → cnt+1.
    - If cnt+1 ≥ effective count: if `last`=1 or `stage`=`stages`-1, go to TRIGGERED. Otherwise stage+1 and cnt=0.
    - No match → cnt=0 and the stage is held. Repeats must be consecutive.
  - **TRIGGERED:** `triggered`=1. Leaves only on `disarm` (to IDLE) or `arm` (restart at stage 0, with `triggered` cleared).
- **Priority:** `disarm` beats `arm` in the same cycle, and both beat the probe evaluation in that cycle.
- **Re-arm:** `arm` while ARMED restarts at stage 0 with cnt=0. No trigger is produced from that cycle's sample.
- **Counter saturation:** cnt saturates at its maximum value and never wraps. With count=255 and cnt_width=8, the stage advances on the 255th consecutive match.

## Timing
- **Reset values:** all outputs 0, state IDLE, cnt 0, and every table field 0 (mask, cond, count and ctrl, so no stage has `last` set).
- **Trigger latency:** a matching sample at edge N (the completing one) gives `trig`=1 and `triggered`=1 after edge N, i.e. during cycle N+1. `trig` deasserts after edge N+1.
- **Stage advance:** `stage` updates on the same edge as the completing match. The new stage is first evaluated on the next sample, so each stage consumes at least one sample.
- **Arm latency:** `armed`=1 the cycle after the `arm` pulse. The first evaluated sample is the one present at the following edge.
- **Config latency:** a write lands on the edge where `cfg_we` is high. It is usable by an `arm` in the next cycle.
- **Async reset mid-sequence:** everything returns to reset values immediately. A `trig` pulse in flight is cut off.

## Structure
- **Shared package `lac_pkg`:**
  - config field codes (FLD_MASK=0, FLD_COND=1, FLD_COUNT=2, FLD_CTRL=3);
  - ctrl bit positions (CTRL_LAST=0, CTRL_NEG=1);
  - state encoding (S_IDLE, S_ARMED, S_TRIG).
- **Sub-module `lac_trig_cmp`:** combinational mask/compare/negate for one stage. Instantiated once and fed by the stage-indexed table mux.
- The table is kept as flops, not RAM, because every field must be reset.

## Test plan
- **Single-stage trigger:** reset; stage 0 = mask FF, cond A5, count 1, ctrl 01; arm; drive 00,00,A5 → `trig` pulses exactly once, the cycle after A5; `triggered` stays 1; `stage`=0.
- **Consecutive-repeat count:** stage 0 = mask 0F, cond 03, count 3, ctrl 01; drive x3,x3,00,x3,x3,x3 → no trigger after the first pair; `trig` after the 6th sample.
- **Three-stage sequence with negation:**
  - stage 0 = FF/11; stage 1 = FF/22; stage 2 = 80/80 with neg=1 and last=1;
  - drive 11,22,80,7F → `stage` goes 0→1→2, holds on 80, and `trig` fires after 7F.
- **Config while armed:** arm, then write stage 0 mask → `cfg_err`=1 and the table is unchanged (read back via behaviour); the next `arm` clears `cfg_err`.
- **Simultaneous `arm` + `disarm`, and re-arm:** in ARMED → IDLE (`armed`=0); while in stage 2, `arm` restarts at `stage`=0.
- **Async reset:** assert `reset_n`=0 mid-sequence during the `trig` cycle → `trig`, `triggered` and `stage` are 0 immediately, and the table reads back as zeros.
